// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the 9-bit control pipeline: opcode constants,
// instruction-class codes, the registered control bundle and the pipe FSM states.
package definitions;

   localparam logic [4:0] OP_LOAD   = 5'b11010;
   localparam logic [4:0] OP_STORE  = 5'b11011;
   localparam logic [3:0] OP_BRANCH = 4'b1111;
   localparam logic [8:0] ACK_WORD  = 9'b010001111;

   // Top-two-bit classes of everything that is not load/store/branch/Ack
   localparam logic [1:0] CLS_CONST = 2'b00;
   localparam logic [1:0] CLS_RC    = 2'b01;
   localparam logic [1:0] CLS_ALU   = 2'b10;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      BUBBLE = 2'd1,
      HALTED = 2'd2
   } pipe_state_t;

   typedef struct packed {
      logic       cond_jump;
      logic       abs_rel;
      logic       reg_wr;
      logic       mem_wr;
      logic       load;
      logic       mid1;
      logic       mid2;
      logic [2:0] const_ctl;
      logic [1:0] br_cond;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_pipe_decode.sv
// Combinational instruction decoder: Instruction -> control bundle and register addresses.
// Zero latency, no state; RC-class ops read and write RC_ADDR, branches read BR_BASE + imm.
module ctrl_decode
   import definitions::*;
#(
   parameter int unsigned IW      = 9,
   parameter int unsigned RAW     = 4,
   parameter int unsigned RC_ADDR = 15,
   parameter int unsigned BR_BASE = 11
) (
   input  logic [IW-1:0]  instr,
   output ctrl_t          ctrl,
   output logic           ack,
   output logic [RAW-1:0] rd_addr_a,
   output logic [RAW-1:0] rd_addr_b,
   output logic [RAW-1:0] wr_addr
);

   logic [RAW-1:0] rc;
   logic [RAW-1:0] f_lo;
   logic [RAW-1:0] f_hi;
   logic [RAW-1:0] f_imm;
   logic [RAW-1:0] br_addr;

   assign rc      = RAW'(RC_ADDR);
   assign f_lo    = RAW'(instr[1:0]);
   assign f_hi    = RAW'(instr[3:2]);
   assign f_imm   = RAW'(instr[3:0]);
   assign br_addr = RAW'(BR_BASE) + f_lo;

   always_comb begin
      ctrl      = CTRL_NOP;
      ack       = 1'b0;
      rd_addr_a = '0;
      rd_addr_b = '0;
      wr_addr   = '0;
      if (instr == IW'(ACK_WORD)) begin
         ack = 1'b1;
      end else if (instr[IW-1 -: 5] == OP_LOAD) begin
         ctrl.load   = 1'b1;
         ctrl.reg_wr = 1'b1;
         rd_addr_a   = f_hi;
         rd_addr_b   = f_lo;
         wr_addr     = f_lo;
      end else if (instr[IW-1 -: 5] == OP_STORE) begin
         ctrl.mem_wr = 1'b1;
         rd_addr_a   = f_hi;
         rd_addr_b   = f_lo;
      end else if (instr[IW-1 -: 4] == OP_BRANCH) begin
         // Condition field of zero means an unconditional jump
         ctrl.cond_jump = |instr[3:2];
         ctrl.abs_rel   = instr[4];
         ctrl.br_cond   = instr[3:2];
         rd_addr_a      = br_addr;
         rd_addr_b      = rc;
      end else begin
         case (instr[IW-1 -: 2])
            CLS_CONST: begin
               ctrl.const_ctl = instr[6:4];
               ctrl.reg_wr    = 1'b1;
               rd_addr_a      = rc;
               rd_addr_b      = rc;
               wr_addr        = rc;
            end
            CLS_RC: begin
               ctrl.mid1   = instr[6];
               ctrl.mid2   = instr[5];
               ctrl.reg_wr = 1'b1;
               rd_addr_a   = rc;
               rd_addr_b   = f_imm;
               wr_addr     = rc;
            end
            CLS_ALU: begin
               ctrl.mid1   = instr[6];
               ctrl.mid2   = instr[5];
               ctrl.reg_wr = 1'b1;
               rd_addr_a   = f_lo;
               rd_addr_b   = f_hi;
               wr_addr     = f_lo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// Registered, stall-aware control stage between fetch and execute; 1-cycle decode-to-output.
// StallIn holds the output register; load-use hazards insert LOAD_BUBBLES bubbles via FetchStall.
module ctrl_pipe
   import definitions::*;
#(
   parameter int unsigned IW           = 9,
   parameter int unsigned RAW          = 4,
   parameter int unsigned RC_ADDR      = 15,
   parameter int unsigned BR_BASE      = 11,
   parameter int unsigned LOAD_BUBBLES = 1
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic [IW-1:0]  Instruction,
   input  logic           InstValid,
   input  logic           StallIn,
   input  logic           Flush,
   output logic           FetchStall,
   output logic           OutValid,
   output logic           ConditionalJump,
   output logic           BranchAbsOrRel,
   output logic           RegWrEn,
   output logic           MemWrEn,
   output logic           LoadInst,
   output logic           MiddleFlag1,
   output logic           MiddleFlag2,
   output logic [2:0]     ConstantControl,
   output logic [1:0]     BranchConditions,
   output logic [RAW-1:0] RegReadAddrA,
   output logic [RAW-1:0] RegReadAddrB,
   output logic [RAW-1:0] RegWriteAddr,
   output logic           Halted
);

   localparam logic [1:0] BUB_LOAD = 2'(LOAD_BUBBLES - 1);

   ctrl_t          dec;
   logic           dec_ack;
   logic [RAW-1:0] dec_a;
   logic [RAW-1:0] dec_b;
   logic [RAW-1:0] dec_w;

   ctrl_decode #(
      .IW      (IW),
      .RAW     (RAW),
      .RC_ADDR (RC_ADDR),
      .BR_BASE (BR_BASE)
   ) u_decode (
      .instr     (Instruction),
      .ctrl      (dec),
      .ack       (dec_ack),
      .rd_addr_a (dec_a),
      .rd_addr_b (dec_b),
      .wr_addr   (dec_w)
   );

   pipe_state_t    state, state_nxt;
   logic [1:0]     cnt, cnt_nxt;
   ctrl_t          q, q_nxt;
   logic           vld, vld_nxt;
   logic [RAW-1:0] qa, qa_nxt;
   logic [RAW-1:0] qb, qb_nxt;
   logic [RAW-1:0] qw, qw_nxt;
   logic           hazard;
   logic           stall_req;
   logic           take_bubble;
   logic           take_dec;

   // Conservative: both read addresses compared whether or not the operand is used
   assign hazard = InstValid && vld && q.load && ((dec_a == qw) || (dec_b == qw));

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      stall_req   = 1'b0;
      take_bubble = 1'b0;
      take_dec    = 1'b0;
      if (Flush) begin
         take_bubble = 1'b1;
         cnt_nxt     = 2'd0;
         state_nxt   = (state == HALTED) ? HALTED : RUN;
         stall_req   = (state == HALTED);
      end else if (StallIn) begin
         stall_req = 1'b1;
      end else begin
         case (state)
            HALTED: begin
               take_bubble = 1'b1;
               stall_req   = 1'b1;
            end
            BUBBLE: begin
               take_bubble = 1'b1;
               stall_req   = 1'b1;
               if (cnt <= 2'd1) begin
                  cnt_nxt   = 2'd0;
                  state_nxt = RUN;
               end else begin
                  cnt_nxt = cnt - 2'd1;
               end
            end
            default: begin
               if (hazard) begin
                  take_bubble = 1'b1;
                  stall_req   = 1'b1;
                  cnt_nxt     = BUB_LOAD;
                  state_nxt   = (LOAD_BUBBLES == 1) ? RUN : BUBBLE;
               end else if (InstValid) begin
                  take_dec = 1'b1;
                  if (dec_ack) begin
                     state_nxt = HALTED;
                  end
               end else begin
                  take_bubble = 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      q_nxt   = q;
      vld_nxt = vld;
      qa_nxt  = qa;
      qb_nxt  = qb;
      qw_nxt  = qw;
      if (take_bubble) begin
         q_nxt   = CTRL_NOP;
         vld_nxt = 1'b0;
         qa_nxt  = '0;
         qb_nxt  = '0;
         qw_nxt  = '0;
      end else if (take_dec) begin
         q_nxt   = dec;
         vld_nxt = 1'b1;
         qa_nxt  = dec_a;
         qb_nxt  = dec_b;
         qw_nxt  = dec_w;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= RUN;
         cnt   <= 2'd0;
         q     <= CTRL_NOP;
         vld   <= 1'b0;
         qa    <= '0;
         qb    <= '0;
         qw    <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         q     <= q_nxt;
         vld   <= vld_nxt;
         qa    <= qa_nxt;
         qb    <= qb_nxt;
         qw    <= qw_nxt;
      end
   end

   assign FetchStall       = stall_req && !Reset;
   assign OutValid         = vld;
   assign ConditionalJump  = q.cond_jump;
   assign BranchAbsOrRel   = q.abs_rel;
   assign RegWrEn          = q.reg_wr;
   assign MemWrEn          = q.mem_wr;
   assign LoadInst         = q.load;
   assign MiddleFlag1      = q.mid1;
   assign MiddleFlag2      = q.mid2;
   assign ConstantControl  = q.const_ctl;
   assign BranchConditions = q.br_cond;
   assign RegReadAddrA     = qa;
   assign RegReadAddrB     = qb;
   assign RegWriteAddr     = qw;
   assign Halted           = (state == HALTED);

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe with LOAD_BUBBLES=2: directed scenarios plus a randomized run
// checked against a cycle-level reference model of the stall/bubble/halt rules.
module tb_ctrl_pipe;

   localparam int LB = 2;

   localparam logic [8:0] I_ADD    = 9'b100000110;  // alu, writes R2, reads R2,R1
   localparam logic [8:0] I_LD_R1  = 9'b110100001;  // load R1 <- mem[R0]
   localparam logic [8:0] I_USE_R1 = 9'b100000001;  // alu reading R1
   localparam logic [8:0] I_USE_R3 = 9'b100001111;  // alu reading R3 only
   localparam logic [8:0] I_ST     = 9'b110110110;  // store R2 -> mem[R1]
   localparam logic [8:0] I_ACK    = 9'b010001111;

   typedef struct packed {
      logic       valid, cj, br, rw, mw, ld, m1, m2;
      logic [2:0] cc;
      logic [1:0] bc;
      logic [3:0] ra, rb, wa;
   } bundle_t;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [8:0] Instruction = '0;
   logic       InstValid = 1'b0, StallIn = 1'b0, Flush = 1'b0;
   logic       FetchStall, OutValid, ConditionalJump, BranchAbsOrRel, RegWrEn, MemWrEn;
   logic       LoadInst, MiddleFlag1, MiddleFlag2, Halted;
   logic [2:0] ConstantControl;
   logic [1:0] BranchConditions;
   logic [3:0] RegReadAddrA, RegReadAddrB, RegWriteAddr;

   int tests_run = 0;
   int tests_failed = 0;

   ctrl_pipe #(.IW(9), .RAW(4), .RC_ADDR(15), .BR_BASE(11), .LOAD_BUBBLES(LB)) dut (
      .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .InstValid(InstValid),
      .StallIn(StallIn), .Flush(Flush), .FetchStall(FetchStall), .OutValid(OutValid),
      .ConditionalJump(ConditionalJump), .BranchAbsOrRel(BranchAbsOrRel), .RegWrEn(RegWrEn),
      .MemWrEn(MemWrEn), .LoadInst(LoadInst), .MiddleFlag1(MiddleFlag1), .MiddleFlag2(MiddleFlag2),
      .ConstantControl(ConstantControl), .BranchConditions(BranchConditions),
      .RegReadAddrA(RegReadAddrA), .RegReadAddrB(RegReadAddrB), .RegWriteAddr(RegWriteAddr),
      .Halted(Halted)
   );

   always #5 Clk = ~Clk;

   // Drive one cycle; FetchStall is sampled late in the cycle, outputs are read 1 ns after the edge.
   task automatic apply(input logic [8:0] ins, input logic iv, input logic st, input logic fl,
                        output logic fs_o);
      Instruction = ins;
      InstValid   = iv;
      StallIn     = st;
      Flush       = fl;
      #3;
      fs_o = FetchStall;
      @(posedge Clk);
      #1;
   endtask

   function automatic bundle_t observe();
      return {OutValid, ConditionalJump, BranchAbsOrRel, RegWrEn, MemWrEn, LoadInst,
              MiddleFlag1, MiddleFlag2, ConstantControl, BranchConditions,
              RegReadAddrA, RegReadAddrB, RegWriteAddr};
   endfunction

   // Reference decode straight from the ISA table
   function automatic bundle_t ref_decode(input logic [8:0] i);
      bundle_t b = '0;
      b.valid = 1'b1;
      if (i == I_ACK) begin
      end else if (i[8:4] == 5'b11010) begin
         b.ld = 1; b.rw = 1; b.ra = 4'(i[3:2]); b.rb = 4'(i[1:0]); b.wa = 4'(i[1:0]);
      end else if (i[8:4] == 5'b11011) begin
         b.mw = 1; b.ra = 4'(i[3:2]); b.rb = 4'(i[1:0]);
      end else if (i[8:5] == 4'b1111) begin
         b.cj = (i[3:2] != 2'b00); b.br = i[4]; b.bc = i[3:2];
         b.ra = 4'(i[1:0]) + 4'd11; b.rb = 4'd15;
      end else if (i[8:7] == 2'b00) begin
         b.cc = i[6:4]; b.rw = 1; b.ra = 4'd15; b.rb = 4'd15; b.wa = 4'd15;
      end else if (i[8:7] == 2'b01) begin
         b.m1 = i[6]; b.m2 = i[5]; b.rw = 1; b.ra = 4'd15; b.rb = i[3:0]; b.wa = 4'd15;
      end else if (i[8:7] == 2'b10) begin
         b.m1 = i[6]; b.m2 = i[5]; b.rw = 1; b.ra = 4'(i[1:0]); b.rb = 4'(i[3:2]); b.wa = 4'(i[1:0]);
      end
      return b;
   endfunction

   function automatic logic [8:0] rand_instr();
      int r = $urandom_range(0, 39);
      if (r == 0) return I_ACK;
      if (r < 12) return {5'b11010, 4'($urandom)};
      return 9'($urandom);
   endfunction

   task automatic test_reset();
      logic fs;
      Reset = 1'b1;
      apply(I_ADD, 1'b1, 1'b0, 1'b0, fs);
      tests_run++;
      if (fs !== 1'b0) begin tests_failed++; $display("FAIL reset_fetchstall: got %b want 0", fs); end
      tests_run++;
      if (observe() !== '0 || Halted !== 1'b0) begin
         tests_failed++; $display("FAIL reset_outputs: got %h halted %b want 0", observe(), Halted);
      end
      Reset = 1'b0;
   endtask

   task automatic test_add();
      logic fs;
      apply(I_ADD, 1'b1, 1'b0, 1'b0, fs);
      tests_run++;
      if (fs !== 1'b0) begin tests_failed++; $display("FAIL add_fetchstall: got %b want 0", fs); end
      tests_run++;
      if ({OutValid, RegWrEn, MemWrEn, RegWriteAddr} !== {1'b1, 1'b1, 1'b0, 4'd2}) begin
         tests_failed++; $display("FAIL add_bundle: got v%b we%b mw%b wa%0d want v1 we1 mw0 wa2",
                                  OutValid, RegWrEn, MemWrEn, RegWriteAddr);
      end
      apply(I_ADD, 1'b0, 1'b0, 1'b0, fs);
      tests_run++;
      if ({OutValid, RegWrEn} !== 2'b00) begin
         tests_failed++; $display("FAIL idle_bubble: got v%b we%b want 0 0", OutValid, RegWrEn);
      end
   endtask

   task automatic test_load_use();
      logic fs;
      int stalls = 0;
      apply(I_LD_R1, 1'b1, 1'b0, 1'b0, fs);
      tests_run++;
      if ({OutValid, LoadInst, RegWriteAddr} !== {1'b1, 1'b1, 4'd1}) begin
         tests_failed++; $display("FAIL load_bundle: got v%b ld%b wa%0d want 1 1 1", OutValid, LoadInst, RegWriteAddr);
      end
      for (int k = 0; k < LB; k++) begin
         apply(I_USE_R1, 1'b1, 1'b0, 1'b0, fs);
         stalls += int'(fs);
         tests_run++;
         if (OutValid !== 1'b0) begin tests_failed++; $display("FAIL load_use_bubble%0d: got v%b want 0", k, OutValid); end
      end
      tests_run++;
      if (stalls != LB) begin tests_failed++; $display("FAIL load_use_stalls: got %0d want %0d", stalls, LB); end
      apply(I_USE_R1, 1'b1, 1'b0, 1'b0, fs);
      tests_run++;
      if ({fs, OutValid, RegReadAddrA} !== {1'b0, 1'b1, 4'd1}) begin
         tests_failed++; $display("FAIL load_use_issue: got fs%b v%b ra%0d want fs0 v1 ra1", fs, OutValid, RegReadAddrA);
      end
   endtask

   task automatic test_load_no_hazard();
      logic fs1, fs2;
      logic v1;
      apply(I_LD_R1, 1'b1, 1'b0, 1'b0, fs1);
      v1 = OutValid;
      apply(I_USE_R3, 1'b1, 1'b0, 1'b0, fs2);
      tests_run++;
      if ({fs1, fs2} !== 2'b00) begin tests_failed++; $display("FAIL nohaz_stall: got %b%b want 00", fs1, fs2); end
      tests_run++;
      if ({v1, OutValid, RegWriteAddr} !== {1'b1, 1'b1, 4'd3}) begin
         tests_failed++; $display("FAIL nohaz_b2b: got v%b v%b wa%0d want 1 1 3", v1, OutValid, RegWriteAddr);
      end
   endtask

   task automatic test_stall_store();
      logic fs;
      bundle_t held;
      apply(I_ST, 1'b1, 1'b0, 1'b0, fs);
      held = observe();
      tests_run++;
      if ({OutValid, MemWrEn, RegWrEn} !== 3'b110) begin
         tests_failed++; $display("FAIL store_bundle: got v%b mw%b we%b want 1 1 0", OutValid, MemWrEn, RegWrEn);
      end
      for (int k = 0; k < 3; k++) begin
         apply(I_ADD, 1'b1, 1'b1, 1'b0, fs);
         tests_run++;
         if (fs !== 1'b1 || observe() !== held || MemWrEn !== 1'b1) begin
            tests_failed++; $display("FAIL stall_hold%0d: got fs%b out %h want fs1 out %h", k, fs, observe(), held);
         end
      end
      apply(I_ADD, 1'b1, 1'b0, 1'b0, fs);
      tests_run++;
      if ({fs, OutValid, MemWrEn, RegWriteAddr} !== {1'b0, 1'b1, 1'b0, 4'd2}) begin
         tests_failed++; $display("FAIL stall_release: got fs%b v%b mw%b wa%0d want 0 1 0 2", fs, OutValid, MemWrEn, RegWriteAddr);
      end
   endtask

   task automatic test_flush();
      logic fs;
      apply(I_LD_R1, 1'b1, 1'b0, 1'b0, fs);
      apply(I_USE_R1, 1'b1, 1'b0, 1'b0, fs);
      apply(I_USE_R1, 1'b1, 1'b0, 1'b1, fs);
      tests_run++;
      if ({fs, OutValid} !== 2'b00) begin tests_failed++; $display("FAIL flush_bubble: got fs%b v%b want 0 0", fs, OutValid); end
      apply(I_USE_R1, 1'b1, 1'b0, 1'b0, fs);
      tests_run++;
      if ({fs, OutValid} !== 2'b01) begin tests_failed++; $display("FAIL flush_resume: got fs%b v%b want 0 1", fs, OutValid); end
      apply(I_LD_R1, 1'b1, 1'b0, 1'b0, fs);
      apply(I_USE_R1, 1'b1, 1'b0, 1'b1, fs);
      tests_run++;
      if ({fs, OutValid} !== 2'b00) begin tests_failed++; $display("FAIL flush_vs_hazard: got fs%b v%b want 0 0", fs, OutValid); end
      apply(I_USE_R1, 1'b1, 1'b0, 1'b0, fs);
      tests_run++;
      if ({fs, OutValid} !== 2'b01) begin tests_failed++; $display("FAIL flush_no_count: got fs%b v%b want 0 1", fs, OutValid); end
   endtask

   task automatic test_ack_halt();
      logic fs;
      tests_run++;
      if (Halted !== 1'b0) begin tests_failed++; $display("FAIL pre_ack_halted: got %b want 0", Halted); end
      apply(I_ACK, 1'b1, 1'b0, 1'b0, fs);
      tests_run++;
      if ({fs, OutValid, RegWrEn, MemWrEn} !== 4'b0100) begin
         tests_failed++; $display("FAIL ack_issue: got fs%b v%b we%b mw%b want 0 1 0 0", fs, OutValid, RegWrEn, MemWrEn);
      end
      for (int k = 0; k < 4; k++) begin
         apply(I_ADD, 1'b1, 1'b0, 1'b0, fs);
         tests_run++;
         if ({fs, OutValid, Halted} !== 3'b101) begin
            tests_failed++; $display("FAIL halted%0d: got fs%b v%b h%b want 1 0 1", k, fs, OutValid, Halted);
         end
      end
      Reset = 1'b1;
      apply(I_ADD, 1'b1, 1'b0, 1'b0, fs);
      Reset = 1'b0;
      tests_run++;
      if ({fs, Halted, OutValid} !== 3'b000) begin
         tests_failed++; $display("FAIL halt_reset: got fs%b h%b v%b want 0 0 0", fs, Halted, OutValid);
      end
      apply(I_ADD, 1'b1, 1'b0, 1'b0, fs);
      tests_run++;
      if ({fs, OutValid} !== 2'b01) begin tests_failed++; $display("FAIL post_reset_issue: got fs%b v%b want 0 1", fs, OutValid); end
   endtask

   task automatic test_random();
      bundle_t m_out, d, got;
      int m_cnt;
      bit m_halted;
      logic [8:0] ins;
      logic iv, st, fl, rs, hz, exp_fs, fs;
      Reset = 1'b1;
      apply(I_ADD, 1'b0, 1'b0, 1'b0, fs);
      Reset = 1'b0;
      m_out = '0; m_cnt = 0; m_halted = 0; fs = 1'b0; ins = I_ADD;
      for (int c = 0; c < 800; c++) begin
         if (!fs) ins = rand_instr();
         iv = ($urandom_range(0, 7) != 0);
         st = ($urandom_range(0, 7) == 0);
         fl = ($urandom_range(0, 11) == 0);
         rs = m_halted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 99) == 0);
         Reset = rs;
         d  = ref_decode(ins);
         hz = iv && m_out.valid && m_out.ld && (d.ra == m_out.wa || d.rb == m_out.wa);
         if (rs)                            exp_fs = 1'b0;
         else if (fl)                       exp_fs = m_halted;
         else if (st || m_halted || m_cnt > 0) exp_fs = 1'b1;
         else                               exp_fs = hz;
         apply(ins, iv, st, fl, fs);
         if (rs) begin
            m_out = '0; m_cnt = 0; m_halted = 0;
         end else if (fl) begin
            m_out = '0; m_cnt = 0;
         end else if (st) begin
         end else if (m_halted) begin
            m_out = '0;
         end else if (m_cnt > 0) begin
            m_out = '0; m_cnt--;
         end else if (hz) begin
            m_out = '0; m_cnt = LB - 1;
         end else if (iv) begin
            m_out = d;
            if (ins == I_ACK) m_halted = 1;
         end else begin
            m_out = '0;
         end
         got = observe();
         tests_run++;
         if (fs !== exp_fs) begin tests_failed++; $display("FAIL rand_fetchstall c%0d: got %b want %b", c, fs, exp_fs); end
         tests_run++;
         if (got !== m_out || Halted !== m_halted) begin
            tests_failed++; $display("FAIL rand_out c%0d: got %h h%b want %h h%b", c, got, Halted, m_out, m_halted);
         end
      end
      Reset = 1'b0;
   endtask

   initial begin
      @(posedge Clk);
      #1;
      test_reset();
      test_add();
      test_load_use();
      test_load_no_hazard();
      test_stall_store();
      test_flush();
      test_ack_halt();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Registered, stall-aware successor to the combinational control decoder of the 9-bit processor. It sits between instruction fetch and execute. Each cycle it decodes one instruction into the existing control bundle and holds that bundle in a pipeline register. It also inserts bubbles for load-use hazards, honours back-pressure and branch flushes from execute, and latches the halt (Ack) condition. Widths and load latency are parameters, so the same block serves wider ISA experiments.

## Interface
- IW, 9: instruction width
- RAW, 4: register address width
- RC_ADDR, 15: register index used as RC
- BR_BASE, 11: base register for branch-target reads (A = Instruction[1:0] + BR_BASE)
- LOAD_BUBBLES, 1: bubbles inserted after a load whose destination is read (1..3)

- Clk  in  1  clock
- Reset  in  1  synchronous, active-high; one clock, one reset domain
- Instruction  in  IW  machine code from instruction ROM
- InstValid  in  1  Instruction is meaningful this cycle
- StallIn  in  1  execute cannot accept; hold output register
- Flush  in  1  taken branch in execute; kill the held instruction
- FetchStall  out  1  combinational; fetch must hold PC and re-present Instruction
- OutValid  out  1  registered bundle is a real instruction
- ConditionalJump, BranchAbsOrRel, RegWrEn, MemWrEn, LoadInst, MiddleFlag1, MiddleFlag2  out  1 each  registered control
- ConstantControl  out  3; BranchConditions  out  2  registered control
- RegReadAddrA, RegReadAddrB, RegWriteAddr  out  RAW  registered addresses
- Halted  out  1  registered; set by Ack, sticky until Reset

## Operation
- Decode table is unchanged from the current ISA:
  - load = [8:4]==11010
  - store = [8:4]==11011
  - branch = [8:5]==1111
  - Ack = 010001111
  - RC-class ops read and write RC_ADDR
- The combinational decode is recomputed from Instruction every cycle.
- States: RUN, BUBBLE, HALTED.
- RUN:
  - A valid, non-hazard instruction is captured: OutValid=1 next cycle.
  - InstValid=0 captures a bubble: OutValid=0 and every enable 0.
- Hazard condition: the output register holds a valid LoadInst with RegWriteAddr=W, and the incoming valid instruction has RegReadAddrA==W or RegReadAddrB==W. Addresses are compared regardless of operand use (conservative).
- On a hazard in RUN:
  - FetchStall=1.
  - A bubble is captured.
  - The bubble counter loads LOAD_BUBBLES-1.
  - Go to BUBBLE, or stay in RUN if LOAD_BUBBLES==1.
- BUBBLE: FetchStall=1 and bubbles are captured while the counter is >0. The counter decrements each cycle; at 0 the block returns to RUN and re-decodes.
- Ack captured as valid: OutValid=1 for that cycle. Next state is HALTED.
- HALTED:
  - FetchStall=1, OutValid=0.
  - Input is ignored.
  - Halted=1 until Reset.
- Priority, highest first: Reset > Flush > StallIn > hazard > normal capture.
  - Flush: the output register loads a bubble, the counter clears, and the state goes to RUN, unless HALTED, which is retained. FetchStall=0 that cycle.
  - StallIn (no Flush): the output register holds its value, the counter and state are frozen, and FetchStall=1.
- A store is never a hazard source; only LoadInst is.

## Timing
- Decode-to-output latency: 1 cycle.
- FetchStall is combinational from current state, StallIn, Flush and the hazard compare. There is no path from outputs back to Instruction within the block.
- Reset values, effective the cycle after Reset is sampled high:
  - all control outputs 0, OutValid 0, Halted 0
  - state RUN, counter 0
  - FetchStall 0 while Reset is high
- Reset asserted mid-bubble or while HALTED returns to RUN with no residual stall.
- Flush and hazard in the same cycle: the flush wins and no bubble count is loaded.
- StallIn and hazard in the same cycle: the hold wins, and the hazard is re-evaluated when StallIn drops.

## Structure
- Shared package `definitions`:
  - opcode constants: OP_LOAD, OP_STORE, OP_BRANCH, ACK_WORD
  - the control-bundle struct ctrl_t
  - the state enum pipe_state_t
- One sub-module, `ctrl_decode`: purely combinational Instruction→ctrl_t, parametrised by IW/RAW/RC_ADDR/BR_BASE.
- `ctrl_pipe` owns the output register, hazard compare, counter and FSM.

## Test plan
- Reset, then valid `add` (op 1000_0110 style, write R2) → one cycle later OutValid=1, RegWrEn=1, RegWriteAddr=2; FetchStall stays 0.
- Load writing R1, followed by an instruction reading R1, LOAD_BUBBLES=2 → FetchStall=1 for 2 cycles, two OutValid=0 bubbles, then the consumer issues with OutValid=1.
- Load writing R1, followed by an instruction reading R3 only → no stall; back-to-back OutValid=1.
- StallIn high for 3 cycles with a valid store held → outputs are constant, MemWrEn=1 is held, FetchStall=1; release resumes with the next instruction.
- Flush during a hazard bubble → the next output is a bubble, FetchStall=0, the counter is cleared, and the following instruction issues.
- Ack (010001111) → OutValid=1 for one cycle, then Halted=1 and FetchStall=1 indefinitely; Reset clears both.
